// File: rtl/aes_ctrl_pkg.sv
// Shared constants and FSM state type for the two-channel AES core arbiter.
package aes_ctrl_pkg;
  localparam int   AES_W              = 128;
  localparam logic MODE_ENC           = 1'b0;
  localparam logic MODE_DEC           = 1'b1;
  localparam int   TIMEOUT_CYCLES_DEF = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;
endpackage

// File: rtl/aes_rr_arb2.sv
// Two-way round-robin grant: the pointed-to channel wins if it requests, else the other one.
module aes_rr_arb2
  import aes_ctrl_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       rr_ptr_i,
  output logic [1:0] gnt_o
);
  always_comb begin
    gnt_o = 2'b00;
    if (req_i[rr_ptr_i]) begin
      gnt_o[rr_ptr_i] = 1'b1;
    end else if (req_i[~rr_ptr_i]) begin
      gnt_o[~rr_ptr_i] = 1'b1;
    end
  end
endmodule

// File: rtl/aes_core_arbiter.sv
// Shares one AES core between two request channels, one operation in flight at a time.
// Optional WAIT timeout (rsp_err) is built when AES_ARB_TIMEOUT_EN is defined.
module aes_core_arbiter
  import aes_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_mode,
  input  logic [1:0][AES_W-1:0] req_data,
  input  logic [1:0][AES_W-1:0] req_key,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [AES_W-1:0]      rsp_data,
  output logic                  rsp_err,
  output logic [AES_W-1:0]      plain_text_in,
  output logic [AES_W-1:0]      cipher_key_in,
  output logic                  cipher_new_en,
  output logic [AES_W-1:0]      cipher_text_in,
  output logic [AES_W-1:0]      round_key_10,
  output logic                  en,
  output logic                  decipher_new_en,
  input  logic [AES_W-1:0]      cipher_text_out,
  input  logic [AES_W-1:0]      plain_text_out,
  input  logic                  cipher_ready,
  input  logic                  decipher_ready
);
  state_t           state_q, state_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             ch_q, ch_d;
  logic             mode_q, mode_d;
  logic [AES_W-1:0] data_q, key_q;
  logic [AES_W-1:0] rsp_data_q, rsp_data_d;
  logic [1:0]       gnt;
  logic             accept, done, timeout, busy, is_enc;

  aes_rr_arb2 u_arb (
    .req_i    (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (gnt)
  );

  assign accept = (state_q == ST_IDLE) && (gnt != 2'b00);
  assign is_enc = (mode_q == MODE_ENC);
  // Only the ready matching the operation in flight counts, and only while waiting.
  assign done   = (state_q == ST_WAIT) && (is_enc ? cipher_ready : decipher_ready);

`ifdef AES_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             rsp_err_q;

  assign timeout = (state_q == ST_WAIT) && !done && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
      if (done || timeout) rsp_err_q <= timeout;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  logic unused_timeout_cycles;
  assign unused_timeout_cycles = ^TIMEOUT_CYCLES;
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ISSUE;
          ch_d    = gnt[1];
          mode_d  = req_mode[gnt[1]];
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          state_d    = ST_RESP;
          rsp_data_d = is_enc ? cipher_text_out : plain_text_out;
        end else if (timeout) begin
          state_d    = ST_RESP;
          rsp_data_d = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready[ch_q]) begin
          state_d  = ST_IDLE;
          rr_ptr_d = ~ch_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= 1'b0;
      ch_q       <= 1'b0;
      mode_q     <= MODE_ENC;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Operand registers are only observed while busy, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      data_q <= req_data[gnt[1]];
      key_q  <= req_key[gnt[1]];
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign req_ready       = (reset_n && !busy) ? gnt : 2'b00;
  assign rsp_valid       = (state_q == ST_RESP) ? (ch_q ? 2'b10 : 2'b01) : 2'b00;
  assign rsp_data        = rsp_data_q;
  assign plain_text_in   = (busy && is_enc)  ? data_q : '0;
  assign cipher_key_in   = (busy && is_enc)  ? key_q  : '0;
  assign cipher_text_in  = (busy && !is_enc) ? data_q : '0;
  assign round_key_10    = (busy && !is_enc) ? key_q  : '0;
  assign cipher_new_en   = (state_q == ST_ISSUE) && is_enc;
  assign decipher_new_en = (state_q == ST_ISSUE) && !is_enc;
  assign en              = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with a transaction-level reference model and a stub AES core.
module tb_aes_core_arbiter;
  import aes_ctrl_pkg::*;

  localparam int TO = 8;
  localparam logic [127:0] K_ENC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] RK10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] req_valid, req_ready, req_mode, rsp_valid, rsp_ready;
  logic [1:0][127:0] req_data, req_key;
  logic [127:0] rsp_data, plain_text_in, cipher_key_in, cipher_text_in, round_key_10;
  logic [127:0] cipher_text_out, plain_text_out;
  logic rsp_err, cipher_new_en, decipher_new_en, en, cipher_ready, decipher_ready;

  logic c_rdy, d_rdy, stray_c, stray_d;
  int core_lat, core_cnt;
  bit core_dec;

  int checks = 0, errors = 0;
  int cyc = 0, t_req = 0, t_rsp = 0, n_rsp = 0, n_enc = 0, n_dec = 0;
  int grants[$];
  logic [127:0] last_data;
  logic last_err, last_ch;

  bit m_busy, m_resp, m_ch, m_mode, m_err, m_rr;
  int m_age, m_wait;
  logic [127:0] m_data, m_key, m_res;

  assign cipher_ready   = c_rdy | stray_c;
  assign decipher_ready = d_rdy | stray_d;

  aes_core_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_mode(req_mode),
    .req_data(req_data), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .plain_text_in(plain_text_in), .cipher_key_in(cipher_key_in), .cipher_new_en(cipher_new_en),
    .cipher_text_in(cipher_text_in), .round_key_10(round_key_10), .en(en),
    .decipher_new_en(decipher_new_en), .cipher_text_out(cipher_text_out),
    .plain_text_out(plain_text_out), .cipher_ready(cipher_ready), .decipher_ready(decipher_ready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic int pick(input bit rr, input logic [1:0] v);
    if (v[rr]) return int'(rr);
    if (v[!rr]) return int'(!rr);
    return -1;
  endfunction

  // Stub core: the known FIPS-197 vectors map to each other, anything else is data^key (^ones for decrypt).
  function automatic logic [127:0] core_fn(input bit dec, input logic [127:0] d, input logic [127:0] k);
    if (!dec && d == PT && k == K_ENC) return CT;
    if (dec && d == CT && k == RK10) return PT;
    return d ^ k ^ {128{dec}};
  endfunction

  initial begin
    core_cnt = 0; core_dec = 0; c_rdy = 0; d_rdy = 0;
    cipher_text_out = '0; plain_text_out = '0;
    forever begin
      @(negedge clk);
      if (cipher_new_en) begin
        core_cnt = core_lat; core_dec = 0;
        cipher_text_out = core_fn(0, plain_text_in, cipher_key_in);
      end
      if (decipher_new_en) begin
        core_cnt = core_lat; core_dec = 1;
        plain_text_out = core_fn(1, cipher_text_in, round_key_10);
      end
      @(posedge clk); #1;
      c_rdy = 0; d_rdy = 0;
      if (core_cnt != 0) begin
        if (core_cnt == 1) begin
          if (core_dec) d_rdy = 1; else c_rdy = 1;
        end
        core_cnt--;
      end
    end
  end

  // Reference model: what one accepted request must look like from the outside.
  initial begin
    int g;
    m_busy = 0; m_resp = 0; m_rr = 0; m_err = 0; m_res = '0; m_data = '0; m_key = '0;
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_resp = 0; m_rr = 0; m_err = 0;
      end else if (!m_busy) begin
        g = pick(m_rr, req_valid);
        if (g >= 0) begin
          m_busy = 1; m_resp = 0; m_ch = g[0]; m_mode = req_mode[g];
          m_data = req_data[g]; m_key = req_key[g]; m_age = 0; m_wait = 0;
        end
      end else if (m_resp) begin
        if (rsp_ready[m_ch]) begin
          m_busy = 0; m_resp = 0; m_rr = !m_ch;
        end
      end else if (m_age == 0) begin
        m_age = 1;
      end else if (m_mode ? decipher_ready : cipher_ready) begin
        m_resp = 1; m_err = 0; m_res = m_mode ? plain_text_out : cipher_text_out;
      end else begin
        m_wait++;
`ifdef AES_ARB_TIMEOUT_EN
        if (m_wait == TO) begin
          m_resp = 1; m_err = 1; m_res = '0;
        end
`endif
      end
    end
  end

  initial begin
    int p;
    logic [1:0] exp_rr;
    bit enc_side, dec_side, prev_rv;
    prev_rv = 0;
    forever begin
      @(negedge clk);
      p = pick(m_rr, req_valid);
      exp_rr = 2'b00;
      if (reset_n && !m_busy && p >= 0) exp_rr = (p == 1) ? 2'b10 : 2'b01;
      enc_side = m_busy && !m_mode;
      dec_side = m_busy && m_mode;
      chk("req_ready", 128'(req_ready), 128'(exp_rr));
      chk("rsp_valid", 128'(rsp_valid), m_resp ? (m_ch ? 128'd2 : 128'd1) : 128'd0);
      chk("en", 128'(en), 128'(m_busy && !m_resp));
      chk("cipher_new_en", 128'(cipher_new_en), 128'(enc_side && !m_resp && m_age == 0));
      chk("decipher_new_en", 128'(decipher_new_en), 128'(dec_side && !m_resp && m_age == 0));
      chk("plain_text_in", plain_text_in, enc_side ? m_data : 128'd0);
      chk("cipher_key_in", cipher_key_in, enc_side ? m_key : 128'd0);
      chk("cipher_text_in", cipher_text_in, dec_side ? m_data : 128'd0);
      chk("round_key_10", round_key_10, dec_side ? m_key : 128'd0);
      if (m_resp) begin
        chk("rsp_data", rsp_data, m_res);
        chk("rsp_err", 128'(rsp_err), 128'(m_err));
      end
      if ((req_valid & req_ready) != 2'b00) begin
        grants.push_back(req_ready[1] ? 1 : 0);
        t_req = cyc;
      end
      if (rsp_valid != 2'b00 && !prev_rv) t_rsp = cyc;
      prev_rv = (rsp_valid != 2'b00);
      if ((rsp_valid & rsp_ready) != 2'b00) begin
        last_data = rsp_data; last_err = rsp_err; last_ch = rsp_valid[1]; n_rsp++;
      end
      n_enc += int'(cipher_new_en);
      n_dec += int'(decipher_new_en);
    end
  end

  task automatic do_req(input int ch, input logic mode, input logic [127:0] d, input logic [127:0] k);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    req_valid[ch] = 1'b1; req_mode[ch] = mode; req_data[ch] = d; req_key[ch] = k;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = req_ready[ch];
      @(posedge clk); #1;
    end
    req_valid[ch] = 1'b0; req_data[ch] = ~d; req_key[ch] = ~k;
    chk("req_accepted", 128'(ok), 128'd1);
  endtask

  task automatic wait_rsp(input int ch, input int hold);
    bit ok;
    ok = 0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid[ch];
    end
    chk("rsp_seen", 128'(ok), 128'd1);
    @(posedge clk); #1;
    rsp_ready[1-ch] = 1'b1;
    repeat (hold) @(posedge clk);
    #1 rsp_ready[1-ch] = 1'b0;
    rsp_ready[ch] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[ch] = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int e0, d0, r0, g0;
    req_valid = '0; req_mode = '0; req_data = '0; req_key = '0; rsp_ready = '0;
    stray_c = 0; stray_d = 0; core_lat = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_req_ready", 128'(req_ready), 128'd0);
    chk("reset_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("reset_rsp_data", rsp_data, 128'd0);
    chk("reset_rsp_err", 128'(rsp_err), 128'd0);
    chk("reset_en_starts", 128'({en, cipher_new_en, decipher_new_en}), 128'd0);
    @(posedge clk); #1 reset_n = 1'b1;

    core_lat = 10; e0 = n_enc; d0 = n_dec; r0 = n_rsp;
    do_req(0, MODE_ENC, PT, K_ENC);
    wait_rsp(0, 3);
    chk("enc_vec_data", last_data, CT);
    chk("enc_vec_err", 128'(last_err), 128'd0);
    chk("enc_vec_ch", 128'(last_ch), 128'd0);
    chk("enc_vec_pulses", 128'(n_enc - e0), 128'd1);
    chk("enc_vec_no_dec", 128'(n_dec - d0), 128'd0);

    core_lat = 4; e0 = n_enc; d0 = n_dec;
    do_req(1, MODE_DEC, CT, RK10);
    wait_rsp(1, 2);
    chk("dec_vec_data", last_data, PT);
    chk("dec_vec_ch", 128'(last_ch), 128'd1);
    chk("dec_vec_pulses", 128'(n_dec - d0), 128'd1);
    chk("dec_vec_no_enc", 128'(n_enc - e0), 128'd0);

    core_lat = 2; g0 = grants.size(); r0 = n_rsp;
    @(posedge clk); #1;
    req_mode = 2'b00; req_data[0] = {16{8'h3c}}; req_key[0] = {16{8'hc3}};
    req_data[1] = {16{8'ha5}}; req_key[1] = {16{8'h0f}};
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 400 && grants.size() < g0 + 4; i++) @(negedge clk);
    @(posedge clk); #1 req_valid = 2'b00;
    for (int i = 0; i < 200 && n_rsp < r0 + 4; i++) @(negedge clk);
    @(posedge clk); #1 rsp_ready = 2'b00;
    chk("rr_responses", 128'(n_rsp - r0), 128'd4);
    for (int i = 0; i < 4; i++)
      chk("rr_grant", 128'((grants.size() > g0 + i) ? grants[g0 + i] : 9), 128'(i % 2));
    chk("rr_last_data", last_data, {16{8'haa}});

    core_lat = 1;
    do_req(0, MODE_ENC, {16{8'h12}}, {16{8'h34}});
    wait_rsp(0, 0);
    chk("min_latency", 128'(t_rsp - t_req), 128'd3);
    chk("min_latency_data", last_data, {16{8'h26}});

    core_lat = 6; r0 = n_rsp;
    do_req(1, MODE_DEC, CT, RK10);
    stray_d = 1;
    @(posedge clk); #1 stray_d = 0; stray_c = 1;
    @(posedge clk); #1 stray_c = 0;
    wait_rsp(1, 0);
    chk("stray_latency", 128'(t_rsp - t_req), 128'd8);
    chk("stray_data", last_data, PT);
    chk("stray_count", 128'(n_rsp - r0), 128'd1);

    core_lat = 20; r0 = n_rsp;
    do_req(0, MODE_ENC, {16{8'h55}}, {16{8'h66}});
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("midrst_en", 128'(en), 128'd0);
    chk("midrst_rsp_valid", 128'(rsp_valid), 128'd0);
    chk("midrst_core_in", plain_text_in | cipher_key_in, 128'd0);
    chk("midrst_rsp_data", rsp_data, 128'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (25) @(negedge clk);
    chk("midrst_no_rsp", 128'(n_rsp - r0), 128'd0);
    core_lat = 3;
    do_req(1, MODE_ENC, {16{8'h0f}}, {16{8'hf0}});
    wait_rsp(1, 1);
    chk("after_rst_data", last_data, {16{8'hff}});
    chk("after_rst_ch", 128'(last_ch), 128'd1);

`ifdef AES_ARB_TIMEOUT_EN
    core_lat = 0; r0 = n_rsp;
    do_req(0, MODE_ENC, {16{8'h77}}, {16{8'h88}});
    for (int i = 0; i < 100 && rsp_valid[0] !== 1'b1; i++) @(negedge clk);
    @(posedge clk); #1 stray_c = 1;
    @(posedge clk); #1 stray_c = 0;
    wait_rsp(0, 1);
    chk("timeout_latency", 128'(t_rsp - t_req), 128'd10);
    chk("timeout_err", 128'(last_err), 128'd1);
    chk("timeout_data", last_data, 128'd0);
    chk("timeout_count", 128'(n_rsp - r0), 128'd1);
`endif

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_core_arbiter.md
AES_CORE_ARBITER -- requirements
Module: aes_core_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the max WAIT cycles before abort; used only with AES_ARB_TIMEOUT_EN.
REQ-002 SHALL have ports, one per line:
  clk  in  1  sole clock, rising edge
  reset_n  in  1  asynchronous active-low reset
  req_valid  in  2  per-channel request valid (channel 0, 1)
  req_ready  out  2  per-channel request accept
  req_mode  in  2  per-channel op: 0 = encrypt, 1 = decrypt
  req_data  in  2x128  per-channel plaintext (enc) or ciphertext (dec)
  req_key  in  2x128  per-channel cipher key (enc) or round-10 key (dec)
  rsp_valid  out  2  per-channel response valid
  rsp_ready  in  2  per-channel response accept
  rsp_data  out  128  result of the granted channel
  rsp_err  out  1  result invalid (timeout)
  plain_text_in  out  128  to core
  cipher_key_in  out  128  to core
  cipher_new_en  out  1  to core, encrypt start pulse
  cipher_text_in  out  128  to core
  round_key_10  out  128  to core
  en  out  1  to core, enable
  decipher_new_en  out  1  to core, decrypt start pulse
  cipher_text_out  in  128  from core
  plain_text_out  in  128  from core
  cipher_ready  in  1  from core, encrypt done
  decipher_ready  in  1  from core, decrypt done

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE; one AES operation in flight.
REQ-004 IDLE: req_ready[g] = 1 combinationally for the granted channel only; handshake on req_valid[g] & req_ready[g]; capture mode/data/key; go ISSUE next cycle.
REQ-005 Grant SHALL be round-robin: pointer rr_ptr picks rr_ptr if valid, else the other; after a channel's response completes, rr_ptr = other channel.
REQ-006 ISSUE (1 cycle): pulse cipher_new_en (enc) or decipher_new_en (dec) exactly one cycle; never both.
REQ-007 Enc: plain_text_in/cipher_key_in = captured data/key. Dec: cipher_text_in/round_key_10 = captured data/key. Unused core inputs SHALL be 0; all core inputs held stable ISSUE through RESP.
REQ-008 en SHALL be 1 in ISSUE and WAIT, 0 otherwise.
REQ-009 WAIT: sample only the matching ready (cipher_ready for enc, decipher_ready for dec); ready during ISSUE and the non-matching ready SHALL be ignored.
REQ-010 On matching ready: register cipher_text_out (enc) or plain_text_out (dec) into rsp_data, rsp_err = 0, go RESP.
REQ-011 RESP: rsp_valid[g] = 1, rsp_data/rsp_err stable until rsp_ready[g]; on handshake go IDLE, rsp_valid = 0.
REQ-012 Minimum latency: rsp_valid rises 3 cycles after request handshake (ready in first WAIT cycle).
REQ-013 req_ready SHALL be 0 in ISSUE/WAIT/RESP; new request accepted earliest the cycle after response handshake.
REQ-014 rsp_ready on a non-granted channel and req_valid dropping after acceptance SHALL have no effect.

Reset
REQ-015 reset_n low SHALL asynchronously force IDLE, rr_ptr = 0, all outputs 0, timeout counter 0.
REQ-016 Reset mid-operation SHALL drop the operation; no response is produced afterwards.

Configuration
REQ-017 With AES_ARB_TIMEOUT_EN defined: WAIT counter counts from 0; when it reaches TIMEOUT_CYCLES without matching ready, go RESP with rsp_data = 0, rsp_err = 1; late ready thereafter ignored.
REQ-018 Without AES_ARB_TIMEOUT_EN: WAIT unbounded, no counter, rsp_err tied 0.

Structure
REQ-019 Package aes_ctrl_pkg SHALL hold AES_W = 128, MODE_ENC = 0, MODE_DEC = 1, FSM state enum, default TIMEOUT_CYCLES.
REQ-020 Round-robin grant SHALL be sub-module aes_rr_arb2 (req[1:0], rr_ptr -> one-hot grant).

Verification
REQ-021 Ch0 enc, key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff, core model ready 10 cycles after start -> one cipher_new_en pulse, rsp_valid[0], rsp_data 69c4e0d86a7b0430d8cdb78070b4c55a, rsp_err 0.
REQ-022 Ch1 dec, data 69c4e0d86a7b0430d8cdb78070b4c55a with round-10 key 13111d7fe3944a17f307a78b4d2b30c5 -> decipher_new_en pulse, rsp_valid[1], rsp_data 00112233445566778899aabbccddeeff.
REQ-023 Both req_valid held high for 4 requests -> grants alternate 0,1,0,1; never two operations in flight.
REQ-024 Stray cipher_ready during a decrypt WAIT -> ignored; response only on decipher_ready.
REQ-025 reset_n low 2 cycles mid-WAIT -> outputs 0, IDLE, no rsp_valid; next request served normally.
REQ-026 With AES_ARB_TIMEOUT_EN, TIMEOUT_CYCLES = 8, core never ready -> rsp_valid with rsp_err 1, rsp_data 0, 8 cycles after entering WAIT.
